// File: rtl/bmem_responder_if.sv
// Burst memory port between a line initiator (master) and the responder
// (slave). A request is held on bmem_read or bmem_write with a fixed
// bmem_address until its transfer ends. bmem_resp is the beat strobe:
// each cycle it is high moves one 64-bit beat, lowest beat first. On a read
// the beat is on bmem_rdata. On a write the beat on bmem_wdata is taken at
// the edge that ends that beat.
interface bmem_if;
    logic [31:0] bmem_address;
    logic        bmem_read;
    logic        bmem_write;
    logic [63:0] bmem_wdata;
    logic [63:0] bmem_rdata;
    logic        bmem_resp;

    modport master (
        output bmem_address,
        output bmem_read,
        output bmem_write,
        output bmem_wdata,
        input  bmem_rdata,
        input  bmem_resp
    );

    modport slave (
        input  bmem_address,
        input  bmem_read,
        input  bmem_write,
        input  bmem_wdata,
        output bmem_rdata,
        output bmem_resp
    );
endinterface

// File: rtl/bmem_responder.sv
// Memory-side responder for the 256-bit line / 64-bit beat burst port.
// It accepts one line request, waits LATENCY cycles, and then moves four
// beats. Writes are staged and reach the array in one update only after the
// final beat. Initiator protocol violations set a sticky flag.
module bmem_responder #(
    parameter int LATENCY = 4,   // 1..255
    parameter int DEPTH   = 256  // power of two >= 2
) (
    input  logic       clk,
    input  logic       rst,
    bmem_if.slave      bus,
    output logic       busy,
    output logic       proto_err,
    output logic [2:0] dbg_state_o
);
    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_RBURST = 3'd2,
        S_WBURST = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic             is_write_q;
    logic [1:0]       beat_q;
    logic [7:0]       cnt_q;
    logic [191:0]     stage_q;     // beats 0..2; beat 3 goes straight to the array
    logic             resp_q;
    logic [63:0]      rdata_q;
    logic             busy_q;
    logic             proto_err_q;

    logic [255:0]     mem_q [DEPTH];

    logic [IDX_W-1:0] req_idx;
    logic [255:0]     rd_line;
    logic [1:0]       next_beat;
    logic             mem_we_d;
    logic [255:0]     wline_d;
    logic             viol;
    logic             unused_addr;

    assign req_idx   = bus.bmem_address[5 +: IDX_W];
    assign rd_line   = mem_q[idx_q];
    assign next_beat = beat_q + 2'd1;
    assign mem_we_d  = (state_q == S_WBURST) && (beat_q == 2'd3);
    assign wline_d   = {bus.bmem_wdata, stage_q};

    // The request must stay exactly as it was when it was accepted.
    assign viol = (is_write_q ? (!bus.bmem_write || bus.bmem_read)
                              : (!bus.bmem_read  || bus.bmem_write))
                  || (req_idx != idx_q);

    // The byte offset and the address bits above the line index do not select anything.
    assign unused_addr = ^{bus.bmem_address[4:0], bus.bmem_address[31:5+IDX_W]};

    assign bus.bmem_resp  = resp_q;
    assign bus.bmem_rdata = rdata_q;
    assign busy           = busy_q;
    assign proto_err      = proto_err_q;
    assign dbg_state_o    = state_q;

    // Transaction FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            is_write_q  <= 1'b0;
            beat_q      <= 2'd0;
            cnt_q       <= 8'd0;
            stage_q     <= '0;
            resp_q      <= 1'b0;
            rdata_q     <= 64'd0;
            busy_q      <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            case (state_q)
                // DONE is a dead cycle: it runs no protocol checks, and the
                // request seen at its closing edge is judged as in IDLE. This
                // gives a back-to-back period of LATENCY+5 cycles.
                S_IDLE, S_DONE: begin
                    if (bus.bmem_read && bus.bmem_write) begin
                        proto_err_q <= 1'b1;
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                    end else if (bus.bmem_read || bus.bmem_write) begin
                        idx_q      <= req_idx;
                        is_write_q <= bus.bmem_write;
                        beat_q     <= 2'd0;
                        cnt_q      <= CNT_INIT;
                        state_q    <= S_WAIT;
                        busy_q     <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (viol) proto_err_q <= 1'b1;
                    if (cnt_q == 8'd0) begin
                        state_q <= is_write_q ? S_WBURST : S_RBURST;
                        resp_q  <= 1'b1;
                        if (!is_write_q) rdata_q <= rd_line[63:0];
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_RBURST: begin
                    if (viol) proto_err_q <= 1'b1;
                    beat_q <= next_beat;
                    if (beat_q == 2'd3) begin
                        state_q <= S_DONE;
                        resp_q  <= 1'b0;
                    end else begin
                        rdata_q <= rd_line[{next_beat, 6'd0} +: 64];
                    end
                end
                S_WBURST: begin
                    if (viol) proto_err_q <= 1'b1;
                    beat_q <= next_beat;
                    if (beat_q == 2'd3) begin
                        state_q <= S_DONE;
                        resp_q  <= 1'b0;
                    end else begin
                        stage_q[{beat_q, 6'd0} +: 64] <= bus.bmem_wdata;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    resp_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Line array has no reset. The full line is written on the final write beat only.
    always_ff @(posedge clk) begin
        if (mem_we_d) mem_q[idx_q] <= wline_d;
    end
endmodule

// File: doc/bmem_responder.md
# bmem_responder

Synthesizable responder for the 64-bit burst memory port driven by `cacheline_adaptor`. It is the memory side of the `bmem_*` interface, used as the physical-memory model in unit and top-level benches and as an on-chip backing store in FPGA builds. It accepts one line request at a time and transfers each 256-bit line as four 64-bit beats after a programmable access latency. It also flags initiator protocol violations.

## Interface
Parameters:
- `LATENCY`, 4: cycles from request acceptance to the first beat; legal range 1..255.
- `DEPTH`, 256: number of 256-bit lines stored; must be a power of two ≥ 2.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `bmem_address`  in  32  byte address; bits [4:0] ignored; line index = `bmem_address[5 +: $clog2(DEPTH)]`; higher bits ignored, so the address space wraps modulo DEPTH lines.
- `bmem_read`  in  1  read request.
- `bmem_write`  in  1  write request.
- `bmem_wdata`  in  64  write beat; sampled on edges where `bmem_resp`=1.
- `bmem_rdata`  out  64  read beat; valid only while `bmem_resp`=1.
- `bmem_resp`  out  1  beat strobe.
- `busy`  out  1  high in every state except IDLE.
- `proto_err`  out  1  sticky violation flag; cleared only by reset.

## Operation
- States: IDLE, WAIT, RBURST, WBURST, DONE.
- IDLE:
  - Exactly one of read/write high at an edge: latch the line index, the direction and `beat`=0; load the latency counter with LATENCY-1; go to WAIT.
  - Both read and write high: set `proto_err`, accept nothing, stay in IDLE.
- WAIT:
  - Decrement the counter each edge.
  - At count 0, go to RBURST or WBURST according to the latched direction.
- RBURST:
  - `bmem_resp`=1 and `bmem_rdata` = line[64·beat +: 64].
  - Increment `beat` each edge; after beat 3, go to DONE.
- WBURST:
  - `bmem_resp`=1; at each edge capture `bmem_wdata` into beat slot `beat` of a 256-bit staging register.
  - After beat 3, write the full staged line into the array in a single update, then go to DONE.
  - A partially received line never reaches the array.
- DONE:
  - Lasts one cycle with `bmem_resp`=0; requests are ignored.
  - Return to IDLE.
- Beat order: beat k maps to bits [64k+63:64k], k=0..3, lowest first.
- Protocol checks while `busy` (WAIT, RBURST, WBURST):
  - The latched request line deasserting, the opposite request asserting, or the line index changing sets `proto_err`.
  - The transaction still completes using the latched index and direction.
- Memory contents are not reset. A read of a never-written line returns undefined data; benches write before reading.

## Timing
- Reset values: state IDLE, `bmem_resp`=0, `bmem_rdata`=0, `busy`=0, `proto_err`=0, counters 0.
- Reset asserted mid-transaction aborts it immediately (asynchronously):
  - `bmem_resp` drops without waiting for a clock edge.
  - An in-progress write is discarded; the array is unchanged.
- Request accepted at edge t0:
  - `busy` is high after t0.
  - `bmem_resp` is high for exactly 4 cycles, from after edge t0+LATENCY to after edge t0+LATENCY+4.
  - DONE occupies the cycle after that.
  - The earliest next acceptance is edge t0+LATENCY+5.
- Back-to-back period is LATENCY+5 cycles per line.
- Write then read of the same line, with the read accepted at the earliest legal edge, returns the new data.
- `bmem_rdata` is registered. It holds its last beat value when `bmem_resp`=0 and returns to 0 only on reset.
- The initiator must hold `bmem_wdata` at beat k until the edge that ends beat k, then advance.

## Test plan
- Reset during WAIT of a read, LATENCY=4 -> `bmem_resp`, `busy` and `proto_err` are 0 immediately; the next request is served normally.
- Write line at 0x0000_0040 with beats 0x1111…, 0x2222…, 0x3333…, 0x4444…, then read 0x0000_0040 -> four beats in the same order; `bmem_resp` high exactly 4 cycles starting 4 cycles after each acceptance.
- Address wrap, DEPTH=256: write 0x0000_2040, read 0x0000_0040 -> same data; read 0x0000_005C (low bits set) -> same data.
- Back-to-back reads of two lines with the request held continuously -> second acceptance exactly LATENCY+5 cycles after the first; no resp gap inside a burst.
- Read and write both high in IDLE -> `proto_err`=1, `busy` stays 0; a later legal request is still served and `proto_err` stays 1.
- `bmem_read` dropped during WAIT -> `proto_err`=1 and the burst still completes 4 beats; LATENCY=1 -> first resp one cycle after acceptance.
